// File: rtl/vga_frame_capture.sv
// ============================================================================
// Module      : vga_frame_capture
// Description : Captures one VGA frame of pixels into M10K memory, then
//               handshakes frame completion with the HPS over ready/ack PIOs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_frame_capture #(
   parameter int H_ACTIVE = 320,
   parameter int V_ACTIVE = 240,
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 17
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sof,
   input  logic              pix_valid,
   input  logic [DATA_W-1:0] pix_data,
   input  logic              ack,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              ready,
   output logic              short_frame
);

   localparam logic [ADDR_W-1:0] c_last_pix = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
   localparam logic [ADDR_W-1:0] c_one      = ADDR_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_CAPTURE      = 2'd1,
      ST_DONE         = 2'd2,
      ST_WAIT_ACK_LOW = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_count;
   logic [ADDR_W-1:0] w_count_nxt;
   logic [ADDR_W-1:0] w_pix_idx;
   logic              w_take;
   logic              w_wr_en_nxt;
   logic [ADDR_W-1:0] w_wr_addr_nxt;
   logic [DATA_W-1:0] w_wr_data_nxt;
   logic              w_ready_nxt;
   logic              w_short_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_count     <= '0;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
         ready       <= 1'b0;
         short_frame <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_count     <= w_count_nxt;
         wr_en       <= w_wr_en_nxt;
         wr_addr     <= w_wr_addr_nxt;
         wr_data     <= w_wr_data_nxt;
         ready       <= w_ready_nxt;
         short_frame <= w_short_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_count_nxt = r_count;
      w_pix_idx   = r_count;
      w_take      = 1'b0;
      w_ready_nxt = 1'b0;
      w_short_nxt = short_frame;

      case (r_state)
         ST_IDLE: begin
            // HPS still holding ack means it has not released the last frame
            if (sof && !ack) begin
               w_state_nxt = ST_CAPTURE;
               w_pix_idx   = '0;
               w_count_nxt = '0;
               w_take      = pix_valid;
            end
         end
         ST_CAPTURE: begin
            if (sof) begin
               w_short_nxt = 1'b1;
               w_pix_idx   = '0;
               w_count_nxt = '0;
            end
            w_take = pix_valid;
         end
         ST_DONE: begin
            w_ready_nxt = !ack;
            if (ack) begin
               w_state_nxt = ST_WAIT_ACK_LOW;
            end
         end
         ST_WAIT_ACK_LOW: begin
            if (!ack) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      // Final pixel parks the counter at the last address so it never wraps
      if (w_take) begin
         if (w_pix_idx == c_last_pix) begin
            w_state_nxt = ST_DONE;
            w_count_nxt = w_pix_idx;
         end else begin
            w_count_nxt = w_pix_idx + c_one;
         end
      end

      w_wr_en_nxt   = w_take;
      w_wr_addr_nxt = w_take ? w_pix_idx : wr_addr;
      w_wr_data_nxt = w_take ? pix_data  : wr_data;
   end

endmodule

`default_nettype wire

// File: tb/tb_vga_frame_capture.sv
// ============================================================================
// Module      : tb_vga_frame_capture
// Description : Directed and randomized checks of vga_frame_capture against
//               a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_frame_capture;

   localparam int H = 4;
   localparam int V = 2;
   localparam int N = H * V;
   localparam int DW = 8;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          sof;
   logic          pix_valid;
   logic [DW-1:0] pix_data;
   logic          ack;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          ready;
   logic          short_frame;

   vga_frame_capture #(
      .H_ACTIVE (H),
      .V_ACTIVE (V),
      .DATA_W   (DW),
      .ADDR_W   (AW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .sof         (sof),
      .pix_valid   (pix_valid),
      .pix_data    (pix_data),
      .ack         (ack),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .ready       (ready),
      .short_frame (short_frame)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;
   int n_writes = 0;

   // Frame-level model: a frame is being filled, is full awaiting ack,
   // or has been acked and waits for ack to drop.
   bit   m_filling, m_full, m_acked, m_short;
   int   m_taken;
   bit   e_we, e_ready;
   int   e_addr;
   logic [DW-1:0] e_data;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_filling = 0; m_full = 0; m_acked = 0; m_short = 0; m_taken = 0;
   endtask

   task automatic accept(input logic [DW-1:0] d);
      e_we   = 1;
      e_addr = m_taken;
      e_data = d;
      m_taken++;
      if (m_taken == N) begin
         m_filling = 0;
         m_full    = 1;
      end
   endtask

   task automatic step(input bit s, input bit pv, input logic [DW-1:0] d, input bit a);
      sof = s; pix_valid = pv; pix_data = d; ack = a;
      e_we    = 0;
      e_ready = m_full && !a;
      if (m_full) begin
         if (a) begin m_full = 0; m_acked = 1; end
      end else if (m_acked) begin
         if (!a) m_acked = 0;
      end else if (m_filling) begin
         if (s) begin m_short = 1; m_taken = 0; end
         if (pv) accept(d);
      end else if (s && !a) begin
         m_filling = 1;
         m_taken   = 0;
         if (pv) accept(d);
      end
      @(posedge clk);
      #1;
      if (wr_en === 1'b1) n_writes++;
      chk("wr_en", 32'(wr_en), 32'(e_we));
      if (e_we) begin
         chk("wr_addr", 32'(wr_addr), 32'(e_addr));
         chk("wr_data", 32'(wr_data), 32'(e_data));
      end
      chk("ready", 32'(ready), 32'(e_ready));
      chk("short_frame", 32'(short_frame), 32'(m_short));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_wr_en"},   32'(wr_en),       32'd0);
      chk({tag, "_wr_addr"}, 32'(wr_addr),     32'd0);
      chk({tag, "_wr_data"}, 32'(wr_data),     32'd0);
      chk({tag, "_ready"},   32'(ready),       32'd0);
      chk({tag, "_short"},   32'(short_frame), 32'd0);
   endtask

   initial begin
      reset = 1'b1; sof = 0; pix_valid = 0; pix_data = '0; ack = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      #2 reset = 1'b0;
      @(posedge clk);
      #1;

      // Full frame with data 0x10..0x17, then ready one cycle after last write
      step(1, 0, 8'h00, 0);
      for (int i = 0; i < N; i++) step(0, 1, 8'(8'h10 + i), 0);
      step(0, 0, 8'h00, 0);
      step(0, 1, 8'h99, 0);

      // Handshake: ack drops ready, sof under ack ignored, fresh capture at 0
      step(0, 0, 8'h00, 1);
      step(1, 1, 8'h77, 1);
      step(0, 0, 8'h00, 0);
      step(1, 1, 8'h55, 0);
      for (int i = 1; i < N; i++) step(0, 1, 8'($urandom), 0);
      step(0, 0, 8'h00, 0);
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 0);

      // Short frame: restart with 0xAA at address 0, then a complete frame
      step(1, 0, 8'h00, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 8'($urandom), 0);
      step(1, 1, 8'hAA, 0);
      for (int i = 1; i < N; i++) step(0, 1, 8'($urandom), 0);
      step(0, 0, 8'h00, 0);
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 0);

      // Gapped pixels every other cycle
      step(1, 0, 8'h00, 0);
      for (int i = 0; i < 2 * N; i++) step(0, (i % 2) == 0, 8'($urandom), 0);
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 0);

      // Reset mid-frame after 5 pixels
      step(1, 0, 8'h00, 0);
      for (int i = 0; i < 5; i++) step(0, 1, 8'($urandom), 0);
      sof = 0; pix_valid = 0; ack = 0;
      reset = 1'b1;
      #1;
      chk_all_zero("midreset");
      model_reset();
      #1 reset = 1'b0;
      for (int i = 0; i < 4; i++) step(0, 1, 8'($urandom), 0);

      // Overrun: ten strobes into an eight-pixel frame
      step(1, 0, 8'h00, 0);
      n_writes = 0;
      for (int i = 0; i < N + 2; i++) step(0, 1, 8'($urandom), 0);
      chk("overrun_writes", 32'(n_writes), 32'(N));
      chk("overrun_ready", 32'(ready), 32'd1);
      step(0, 0, 8'h00, 1);
      step(0, 0, 8'h00, 0);

      // Randomized traffic including sof/pix/ack in every phase
      for (int i = 0; i < 600; i++) begin
         step(($urandom % 12) == 0, $urandom % 2 == 1, 8'($urandom), ($urandom % 6) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
